// File: rtl/fs_serial_4bit_pkg.sv
// Shared types and constants for the bit-serial full subtractor.
// State encodings are kept as plain logic constants alongside the enum
// so legacy code that compares raw state vectors keeps working.
package fs_pkg;

    localparam int FS_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fs_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/fs_serial_4bit_if.sv
// Request/result bundle for fs_serial_4bit.
// The master issues start plus operands; the slave returns status and result.
// Optional macro FS_OVF_EN adds the signed-overflow flag ovf.
interface fs_serial_4bit_if import fs_pkg::*; #(
    parameter int WIDTH = FS_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef FS_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin,
                    input  busy, done, diff, borrow, ovf);
    modport slave  (input  start, a, b, bin,
                    output busy, done, diff, borrow, ovf);
`else
    modport master (output start, a, b, bin,
                    input  busy, done, diff, borrow);
    modport slave  (input  start, a, b, bin,
                    output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/fs_serial_4bit_bit1.sv
// One-bit combinational full subtractor cell: x - y - bi -> d, bo.
module fs_bit1 (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/fs_serial_4bit.sv
// Bit-serial full subtractor: computes a - b - bin one bit per clock using a
// single fs_bit1 cell and a registered borrow chain, under a start/done
// handshake. Results are registered and only change on entry to DONE.
// Optional macro FS_OVF_EN adds a registered signed-overflow output.
module fs_serial_4bit import fs_pkg::*; #(
    parameter int WIDTH = FS_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    fs_serial_4bit_if.slave  bus
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             br;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             d_bit;
    logic             bo_bit;
    logic [WIDTH-1:0] res_cat;
`ifdef FS_OVF_EN
    logic             ovf_q;
`endif

    fs_bit1 u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (br),
        .d  (d_bit),
        .bo (bo_bit)
    );

    // The fresh difference bit enters at the MSB; earlier bits move right.
    assign res_cat = {d_bit, res_sh};

    // FSM, operand shifters, borrow chain, step counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef FS_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        br     <= bus.bin;
                        res_sh <= '0;
                        cnt    <= '0;
                        state  <= ST_SHIFT;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= bo_bit;
                    res_sh <= res_cat[WIDTH-1:1];
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state    <= ST_DONE;
                        diff_q   <= res_cat;
                        borrow_q <= bo_bit;
`ifdef FS_OVF_EN
                        ovf_q    <= br ^ bo_bit;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state == ST_SHIFT);
    assign bus.done   = (state == ST_DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
`ifdef FS_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_fs_serial_4bit.sv
// Testbench for fs_serial_4bit: directed and randomized subtractions checked
// against an integer-arithmetic reference model.
module tb_fs_serial_4bit;
    import fs_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] held_diff;
    logic         held_borrow;
`ifdef FS_OVF_EN
    logic         held_ovf;
`endif

    fs_serial_4bit_if #(.WIDTH(W)) bus ();

    fs_serial_4bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Reference: plain integer subtraction, unsigned borrow, signed overflow.
    function automatic void model(input int a, input int b, input int bin,
                                  output logic [W-1:0] d, output logic bo,
                                  output logic ov);
        int r, sa, sb, sr;
        r  = a - b - bin;
        d  = W'(r);
        bo = (a < b + bin);
        sa = (a >= 2 ** (W - 1)) ? a - 2 ** W : a;
        sb = (b >= 2 ** (W - 1)) ? b - 2 ** W : b;
        sr = sa - sb - bin;
        ov = (sr > 2 ** (W - 1) - 1) || (sr < -(2 ** (W - 1)));
    endfunction

    // Present operands with start for one edge; returns #1 after the accept edge.
    task automatic launch(input int a, input int b, input int bin);
        bus.a     = W'(a);
        bus.b     = W'(b);
        bus.bin   = 1'(bin);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done; flags any busy drop, early done or result change mid-shift.
    task automatic wait_done(input bit noise, output int cyc, output bit bad_mid);
        cyc     = 0;
        bad_mid = 1'b0;
        for (int k = 1; k <= W + 4; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                bus.start = 1'b0;
                cyc = k;
                break;
            end
            if (!bus.busy || bus.diff !== held_diff || bus.borrow !== held_borrow)
                bad_mid = 1'b1;
            if (noise) begin
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.bin   = 1'($urandom);
                bus.start = 1'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
        end
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_done: got %b expected 0", bus.done);
        end
        vectors++;
        if (bus.diff !== '0 || bus.borrow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_result: got diff=%h borrow=%b expected 0/0", bus.diff, bus.borrow);
        end
`ifdef FS_OVF_EN
        vectors++;
        if (bus.ovf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ovf: got %b expected 0", bus.ovf);
        end
        held_ovf = 1'b0;
`endif
        bus.start = 1'b0;
        rst = 1'b0;
        held_diff = '0;
        held_borrow = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One complete operation with all result and handshake checks.
    task automatic test_directed();
        int tbl [6][3] = '{'{9, 3, 0}, '{3, 9, 0}, '{0, 0, 1},
                           '{8, 1, 0}, '{5, 2, 0}, '{15, 15, 1}};
        logic [W-1:0] ed;
        logic eb, eo;
        int cyc;
        bit bad;
        for (int i = 0; i < 6; i++) begin
            model(tbl[i][0], tbl[i][1], tbl[i][2], ed, eb, eo);
            launch(tbl[i][0], tbl[i][1], tbl[i][2]);
            vectors++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL dir%0d_accept: got busy=%b done=%b expected 1/0", i, bus.busy, bus.done);
            end
            wait_done(1'b0, cyc, bad);
            vectors++;
            if (cyc !== W) begin
                miscompares++;
                $display("[TB] FAIL dir%0d_latency: got %0d expected %0d", i, cyc, W);
            end
            vectors++;
            if (bad !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL dir%0d_midshift: got %b expected 0", i, bad);
            end
            vectors++;
            if (bus.diff !== ed || bus.borrow !== eb || bus.busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL dir%0d_result: got diff=%h borrow=%b busy=%b expected %h/%b/0",
                         i, bus.diff, bus.borrow, bus.busy, ed, eb);
            end
`ifdef FS_OVF_EN
            vectors++;
            if (bus.ovf !== eo) begin
                miscompares++;
                $display("[TB] FAIL dir%0d_ovf: got %b expected %b", i, bus.ovf, eo);
            end
            held_ovf = eo;
`endif
            held_diff = ed;
            held_borrow = eb;
            @(posedge clk);
            #1;
            vectors++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL dir%0d_after: got done=%b busy=%b expected 0/0", i, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] ed;
        logic eb, eo;
        int cyc;
        int extra;
        bit bad;
        model(12, 5, 0, ed, eb, eo);
        launch(12, 5, 0);
        wait_done(1'b1, cyc, bad);
        vectors++;
        if (cyc !== W || bad !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ignore_timing: got cyc=%0d bad=%b expected %0d/0", cyc, bad, W);
        end
        vectors++;
        if (bus.diff !== ed || bus.borrow !== eb) begin
            miscompares++;
            $display("[TB] FAIL ignore_result: got %h/%b expected %h/%b", bus.diff, bus.borrow, ed, eb);
        end
        held_diff = ed;
        held_borrow = eb;
`ifdef FS_OVF_EN
        held_ovf = eo;
`endif
        extra = 0;
        for (int k = 0; k < W + 3; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("[TB] FAIL ignore_single_done: got %0d extra active cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ed;
        logic eb, eo;
        int cyc;
        bit bad;
        launch(6, 4, 0);
        wait_done(1'b0, cyc, bad);
        vectors++;
        if (cyc !== W || bus.diff !== 4'h2) begin
            miscompares++;
            $display("[TB] FAIL b2b_first: got cyc=%0d diff=%h expected %0d/2", cyc, bus.diff, W);
        end
        held_diff = 4'h2;
        held_borrow = 1'b0;
        model(15, 15, 1, ed, eb, eo);
        launch(15, 15, 1);
        wait_done(1'b0, cyc, bad);
        vectors++;
        if (cyc + 1 !== W + 1 || bad !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_spacing: got %0d cycles bad=%b expected %0d/0", cyc + 1, bad, W + 1);
        end
        vectors++;
        if (bus.diff !== ed || bus.borrow !== eb) begin
            miscompares++;
            $display("[TB] FAIL b2b_result: got %h/%b expected %h/%b", bus.diff, bus.borrow, ed, eb);
        end
        held_diff = ed;
        held_borrow = eb;
`ifdef FS_OVF_EN
        held_ovf = eo;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        int stray;
        bit bad;
        launch(13, 6, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== '0 || bus.borrow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: got busy=%b done=%b diff=%h borrow=%b expected all 0",
                     bus.busy, bus.done, bus.diff, bus.borrow);
        end
        held_diff = '0;
        held_borrow = 1'b0;
        stray = 0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_idle: got %0d active cycles expected 0", stray);
        end
        launch(7, 2, 0);
        wait_done(1'b0, cyc, bad);
        vectors++;
        if (cyc !== W || bus.diff !== 4'h5 || bus.borrow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_recover: got cyc=%0d diff=%h borrow=%b expected %0d/5/0",
                     cyc, bus.diff, bus.borrow, W);
        end
        held_diff = 4'h5;
        held_borrow = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [W-1:0] ed;
        logic eb, eo;
        int ra, rb, rc, cyc;
        bit bad;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom_range(0, 2 ** W - 1);
            rb = $urandom_range(0, 2 ** W - 1);
            rc = $urandom_range(0, 1);
            model(ra, rb, rc, ed, eb, eo);
            launch(ra, rb, rc);
            wait_done(1'($urandom), cyc, bad);
            vectors++;
            if (cyc !== W || bad !== 1'b0 || bus.diff !== ed || bus.borrow !== eb) begin
                miscompares++;
                $display("[TB] FAIL rand%0d: a=%0d b=%0d bin=%0d got cyc=%0d bad=%b diff=%h borrow=%b expected %0d/0/%h/%b",
                         i, ra, rb, rc, cyc, bad, bus.diff, bus.borrow, W, ed, eb);
            end
`ifdef FS_OVF_EN
            vectors++;
            if (bus.ovf !== eo) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_ovf: got %b expected %b", i, bus.ovf, eo);
            end
            held_ovf = eo;
`endif
            held_diff = ed;
            held_borrow = eb;
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        rst       = 1'b1;
        held_diff = '0;
        held_borrow = 1'b0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
